regfile_read_port: RTL and testbench

//   Dual read port for the 32x32 register bank: the read side that pairs with the one-hot-write register array.

---
 rtl/regfile_read_port.sv | 136 +++++++++++++
 tb/tb_regfile_read_port.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - dual-operand read port for the 32x32 register bank
//
// Purpose:
//   Accepts (ra, rb) read requests over a valid/ready handshake and returns
//   both operands two cycles after acceptance. A write landing in the same
//   edge that samples an operand is forwarded, so the reader sees the new
//   value. Register 0 can be hard-wired to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   q_flat     register contents {Q(NREGS-1),...,Q0}, Qn = q_flat[n*WIDTH +: WIDTH]
//   regwrite   a write to the bank commits at this clock edge
//   wr_addr    index of the register being written
//   wr_data    data being written
//   req_valid  read request present
//   req_ready  port can accept a request this cycle
//   ra, rb     operand A / B register indices
//   rsp_valid  response present
//   rsp_ready  consumer accepts the response
//   rsp_a      operand A data
//   rsp_b      operand B data
//   rsp_fwd    [0]: A was forwarded, [1]: B was forwarded

module regfile_read_port #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 32,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREGS*WIDTH-1:0] q_flat,
  input  logic                   regwrite,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          ra,
  input  logic [AW-1:0]          rb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_a,
  output logic [WIDTH-1:0]       rsp_b,
  output logic [1:0]             rsp_fwd
);

  // Stage 1: captured request indices.
  logic          r_v1;
  logic [AW-1:0] r_ra1;
  logic [AW-1:0] r_rb1;

  // Stage 2: response registers.
  logic             r_v2;
  logic [WIDTH-1:0] r_rsp_a;
  logic [WIDTH-1:0] r_rsp_b;
  logic [1:0]       r_rsp_fwd;

  logic w_adv2;
  logic w_adv1;
  logic w_accept;

  logic [WIDTH-1:0] w_data_a;
  logic [WIDTH-1:0] w_data_b;
  logic             w_fwd_a;
  logic             w_fwd_b;

  // S2 can take new data when it is empty or its contents leave this cycle;
  // S1 moves forward only when it holds something and S2 can take it.
  assign w_adv2    = !r_v2 || rsp_ready;
  assign w_adv1    = r_v1 && w_adv2;
  assign req_ready = !r_v1 || w_adv2;
  assign w_accept  = req_valid && req_ready;

  // Operand selection for the indices sitting in S1. Priority: hard zero
  // for R0, then a same-edge write (forwarded), then the bank contents.
  always_comb begin
    w_data_a = q_flat[int'(r_ra1)*WIDTH +: WIDTH];
    w_fwd_a  = 1'b0;
    if ((ZERO_R0 != 0) && (r_ra1 == '0)) begin
      w_data_a = '0;
    end else if (regwrite && (wr_addr == r_ra1)) begin
      w_data_a = wr_data;
      w_fwd_a  = 1'b1;
    end
  end

  always_comb begin
    w_data_b = q_flat[int'(r_rb1)*WIDTH +: WIDTH];
    w_fwd_b  = 1'b0;
    if ((ZERO_R0 != 0) && (r_rb1 == '0)) begin
      w_data_b = '0;
    end else if (regwrite && (wr_addr == r_rb1)) begin
      w_data_b = wr_data;
      w_fwd_b  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_ra1 <= '0;
      r_rb1 <= '0;
    end else begin
      r_v1 <= w_accept || (r_v1 && !w_adv2);
      if (w_accept) begin
        r_ra1 <= ra;
        r_rb1 <= rb;
      end
    end
  end

  // Data registers load only when S1 advances; a stalled response is a
  // snapshot and is deliberately not refreshed by later writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2      <= 1'b0;
      r_rsp_a   <= '0;
      r_rsp_b   <= '0;
      r_rsp_fwd <= 2'b00;
    end else begin
      r_v2 <= w_adv1 || (r_v2 && !rsp_ready);
      if (w_adv1) begin
        r_rsp_a   <= w_data_a;
        r_rsp_b   <= w_data_b;
        r_rsp_fwd <= {w_fwd_b, w_fwd_a};
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_a     = r_rsp_a;
  assign rsp_b     = r_rsp_b;
  assign rsp_fwd   = r_rsp_fwd;

endmodule

// File: tb/tb_regfile_read_port.sv
// tb/tb_regfile_read_port.sv - directed bench for regfile_read_port

module tb_regfile_read_port;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic                   clk;
  logic                   rst;
  logic [NREGS*WIDTH-1:0] q_flat;
  logic                   regwrite;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   req_valid;
  logic [AW-1:0]          ra;
  logic [AW-1:0]          rb;
  logic                   rsp_ready;

  logic             req_ready,  req_ready_n;
  logic             rsp_valid,  rsp_valid_n;
  logic [WIDTH-1:0] rsp_a,      rsp_a_n;
  logic [WIDTH-1:0] rsp_b,      rsp_b_n;
  logic [1:0]       rsp_fwd,    rsp_fwd_n;

  int checks   = 0;
  int failures = 0;

  regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .q_flat(q_flat), .regwrite(regwrite),
    .wr_addr(wr_addr), .wr_data(wr_data), .req_valid(req_valid),
    .req_ready(req_ready), .ra(ra), .rb(rb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_fwd(rsp_fwd)
  );

  regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_R0(0)) dut_nz (
    .clk(clk), .rst(rst), .q_flat(q_flat), .regwrite(regwrite),
    .wr_addr(wr_addr), .wr_data(wr_data), .req_valid(req_valid),
    .req_ready(req_ready_n), .ra(ra), .rb(rb), .rsp_valid(rsp_valid_n),
    .rsp_ready(rsp_ready), .rsp_a(rsp_a_n), .rsp_b(rsp_b_n), .rsp_fwd(rsp_fwd_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input int n, input logic [WIDTH-1:0] v);
    q_flat[n*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    // Reset with random inputs.
    rst       = 1'b1;
    q_flat    = '0;
    for (int n = 0; n < NREGS; n++) set_q(n, $urandom);
    regwrite  = 1'($urandom);
    wr_addr   = 5'($urandom);
    wr_data   = $urandom;
    req_valid = 1'($urandom);
    ra        = 5'($urandom);
    rb        = 5'($urandom);
    rsp_ready = 1'($urandom);
    step();
    step();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_a",     64'(rsp_a),     64'd0);
    chk("rst_rsp_b",     64'(rsp_b),     64'd0);
    chk("rst_rsp_fwd",   64'(rsp_fwd),   64'd0);
    chk("rst_nz_valid",  64'(rsp_valid_n), 64'd0);

    // Known bank contents: Qn = 0x1000_0000 + n, with a few overrides.
    for (int n = 0; n < NREGS; n++) set_q(n, 32'h1000_0000 + n);
    set_q(0, 32'hFFFF_FFFF);
    set_q(5, 32'hDEAD_BEEF);
    set_q(7, 32'h0000_0001);
    set_q(9, 32'h1234_5678);
    regwrite  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    req_valid = 1'b0;
    ra        = '0;
    rb        = '0;
    rsp_ready = 1'b1;
    rst       = 1'b0;
    step();

    // Basic read: ra=5, rb=9.
    req_valid = 1'b1; ra = 5'd5; rb = 5'd9;
    step();
    req_valid = 1'b0;
    chk("basic_lat_valid0", 64'(rsp_valid), 64'd0);
    step();
    chk("basic_valid", 64'(rsp_valid), 64'd1);
    chk("basic_a",     64'(rsp_a),     64'hDEAD_BEEF);
    chk("basic_b",     64'(rsp_b),     64'h1234_5678);
    chk("basic_fwd",   64'(rsp_fwd),   64'd0);

    // Forwarding: ra=rb=7 sampled while a write to R7 commits.
    req_valid = 1'b1; ra = 5'd7; rb = 5'd7;
    step();
    req_valid = 1'b0;
    regwrite = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE_0007;
    step();
    regwrite = 1'b0;
    chk("fwd_valid", 64'(rsp_valid), 64'd1);
    chk("fwd_a",     64'(rsp_a),     64'hCAFE_0007);
    chk("fwd_b",     64'(rsp_b),     64'hCAFE_0007);
    chk("fwd_fwd",   64'(rsp_fwd),   64'd3);

    // R0: write to R0 during sampling, ra=0, rb=9.
    req_valid = 1'b1; ra = 5'd0; rb = 5'd9;
    step();
    req_valid = 1'b0;
    regwrite = 1'b1; wr_addr = 5'd0; wr_data = 32'hA5A5_0000;
    step();
    regwrite = 1'b0;
    chk("r0_z_a",    64'(rsp_a),   64'd0);
    chk("r0_z_fwd",  64'(rsp_fwd), 64'd0);
    chk("r0_z_b",    64'(rsp_b),   64'h1234_5678);
    chk("r0_nz_valid", 64'(rsp_valid_n), 64'd1);
    chk("r0_nz_a",   64'(rsp_a_n),   64'hA5A5_0000);
    chk("r0_nz_fwd", 64'(rsp_fwd_n), 64'd1);
    step();
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    // Back-pressure: rsp_ready low for 5 edges, requests ra=rb=1..4.
    rsp_ready = 1'b0;
    req_valid = 1'b1; ra = 5'd1; rb = 5'd1;
    step();  // r1 accepted
    chk("bp_rdy_after1", 64'(req_ready), 64'd1);
    chk("bp_valid_after1", 64'(rsp_valid), 64'd0);
    ra = 5'd2; rb = 5'd2;
    step();  // r1 -> S2, r2 accepted
    chk("bp_rdy_after2", 64'(req_ready), 64'd0);
    chk("bp_valid_after2", 64'(rsp_valid), 64'd1);
    chk("bp_a_after2", 64'(rsp_a), 64'h1000_0001);
    ra = 5'd3; rb = 5'd3;
    // Write R1 while the R1 response is stalled: the response must not change.
    regwrite = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0077;
    set_q(1, 32'h0000_0077);
    step();
    regwrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_stall_rdy", 64'(req_ready), 64'd0);
      chk("bp_stall_valid", 64'(rsp_valid), 64'd1);
      chk("bp_stall_a", 64'(rsp_a), 64'h1000_0001);
      chk("bp_stall_b", 64'(rsp_b), 64'h1000_0001);
      if (k < 2) step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(req_ready), 64'd1);
    step();  // r2 -> S2, r3 accepted
    chk("bp_out2_valid", 64'(rsp_valid), 64'd1);
    chk("bp_out2_a", 64'(rsp_a), 64'h1000_0002);
    ra = 5'd4; rb = 5'd4;
    step();  // r3 -> S2, r4 accepted
    req_valid = 1'b0;
    chk("bp_out3_valid", 64'(rsp_valid), 64'd1);
    chk("bp_out3_a", 64'(rsp_a), 64'h1000_0003);
    step();
    chk("bp_out4_valid", 64'(rsp_valid), 64'd1);
    chk("bp_out4_a", 64'(rsp_a), 64'h1000_0004);
    chk("bp_out4_b", 64'(rsp_b), 64'h1000_0004);
    step();
    chk("bp_empty", 64'(rsp_valid), 64'd0);

    // Reset mid-flight with both stages full.
    rsp_ready = 1'b0;
    req_valid = 1'b1; ra = 5'd5; rb = 5'd5;
    step();
    ra = 5'd9; rb = 5'd9;
    step();
    req_valid = 1'b0;
    chk("mid_full_valid", 64'(rsp_valid), 64'd1);
    chk("mid_full_rdy", 64'(req_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rdy", 64'(req_ready), 64'd1);
    chk("mid_rst_a", 64'(rsp_a), 64'd0);
    step();
    #2;
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; ra = 5'd9; rb = 5'd5;
    step();
    req_valid = 1'b0;
    chk("post_rst_valid0", 64'(rsp_valid), 64'd0);
    step();
    chk("post_rst_valid", 64'(rsp_valid), 64'd1);
    chk("post_rst_a", 64'(rsp_a), 64'h1234_5678);
    chk("post_rst_b", 64'(rsp_b), 64'hDEAD_BEEF);
    step();
    chk("post_rst_empty", 64'(rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
